// File: rtl/prog_loader.sv
// Byte-stream program loader: frames bytes into instruction words, validates opcodes and
// writes program memory; holds the CPU in reset until a complete, checksummed image is loaded.
module prog_loader #(
  parameter int         IWIDTH = 24,
  parameter int         AWIDTH = 8,
  parameter logic [7:0] HDR    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              pm_we,
  output logic [AWIDTH-1:0] pm_addr,
  output logic [IWIDTH-1:0] pm_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic [1:0]        err
);

  localparam int NB = IWIDTH / 8;
  localparam int BW = $clog2(NB + 1);

  localparam logic [4:0] OP_IMM  = 5'h01;
  localparam logic [4:0] OP_SWI  = 5'h02;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_ADDI = 5'h04;
  localparam logic [4:0] OP_MUL  = 5'h05;
  localparam logic [4:0] OP_MULI = 5'h06;
  localparam logic [4:0] OP_ST0  = 5'h07;
  localparam logic [4:0] OP_ST1  = 5'h08;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t            state;
  logic [IWIDTH-1:0] word_q;
  logic [BW-1:0]     byte_cnt;
  logic [7:0]        words_left;
  logic [7:0]        chk;

  logic              xfer;
  logic              is_hdr;
  logic              last_byte;
  logic              op_ok;
  logic [IWIDTH-1:0] next_word;

  always_comb begin
    xfer      = in_valid & in_ready;
    is_hdr    = (in_data == HDR);
    next_word = IWIDTH'({word_q, in_data});
    last_byte = (byte_cnt == BW'(NB - 1));
    case (next_word[IWIDTH-1 -: 5])
      OP_IMM, OP_SWI, OP_ADD, OP_ADDI,
      OP_MUL, OP_MULI, OP_ST0, OP_ST1: op_ok = 1'b1;
      default:                         op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      pm_we      <= 1'b0;
      pm_addr    <= '0;
      pm_wdata   <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 2'd0;
      word_q     <= '0;
      byte_cnt   <= '0;
      words_left <= 8'd0;
      chk        <= 8'd0;
    end else begin
      pm_we <= 1'b0;
      case (state)
        // Any terminal state restarts on a header; stray bytes are dropped.
        S_IDLE, S_DONE, S_ERROR: begin
          if (xfer && is_hdr) begin
            state    <= S_COUNT;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 2'd0;
            chk      <= 8'd0;
            byte_cnt <= '0;
            pm_addr  <= '0;
          end
        end
        S_COUNT: begin
          if (xfer) begin
            if (in_data == 8'd0) begin
              state <= S_ERROR;
              err   <= 2'd3;
            end else begin
              words_left <= in_data;
              state      <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            word_q <= next_word;
            chk    <= chk ^ in_data;
            if (last_byte) begin
              byte_cnt <= '0;
              if (op_ok) begin
                state    <= S_WRITE;
                pm_we    <= 1'b1;
                pm_wdata <= next_word;
                in_ready <= 1'b0;
              end else begin
                state <= S_ERROR;
                err   <= 2'd1;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        // One-cycle write bubble: input is stalled while the word is committed.
        S_WRITE: begin
          in_ready   <= 1'b1;
          pm_addr    <= pm_addr + 1'b1;
          words_left <= words_left - 8'd1;
          state      <= (words_left == 8'd1) ? S_CHECK : S_DATA;
        end
        S_CHECK: begin
          if (xfer) begin
            if (in_data == chk) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERROR;
              err   <= 2'd2;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame loads, opcode/checksum/count errors, junk and mid-frame reset.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        pm_we;
  logic [7:0]  pm_addr;
  logic [23:0] pm_wdata;
  logic        cpu_hold;
  logic        done;
  logic [1:0]  err;

  int n_cmp = 0;
  int n_bad = 0;
  int ready_bad = 0;
  logic [7:0]  wa[$];
  logic [23:0] wd[$];
  logic [23:0] fw[4];

  prog_loader #(.IWIDTH(24), .AWIDTH(8), .HDR(8'hA5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Write log and stall-bubble observer, sampled on the inactive edge.
  always @(negedge clk) begin
    if (pm_we) begin
      wa.push_back(pm_addr);
      wd.push_back(pm_wdata);
    end
    if (in_ready !== !pm_we) ready_bad++;
  end

  task automatic send(input logic [7:0] b, input bit gaps);
    int n;
    @(negedge clk);
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Sends COUNT, the words in fw, then the checksum XOR flip.
  task automatic send_body(input int n, input logic [7:0] flip, input bit gaps);
    logic [7:0] c;
    logic [23:0] w;
    c = 8'h00;
    send(8'(n), gaps);
    for (int i = 0; i < n; i++) begin
      w = fw[i];
      c = c ^ w[23:16] ^ w[15:8] ^ w[7:0];
      send(w[23:16], gaps);
      send(w[15:8], gaps);
      send(w[7:0], gaps);
    end
    send(c ^ flip, gaps);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    ready_bad = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({in_ready, pm_we, cpu_hold, done, err} !== 6'b101000) begin
      n_bad++; $display("FAIL reset_ctl: rdy/we/hold/done/err=%b required 101000", {in_ready, pm_we, cpu_hold, done, err});
    end
    n_cmp++; if (pm_addr !== 8'h00 || pm_wdata !== 24'h0) begin
      n_bad++; $display("FAIL reset_bus: addr=%h wdata=%h required 00/000000", pm_addr, pm_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    clear_log();
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h21, 0);
    send(8'h23, 0);
    send(8'h45, 0);
    n_cmp++; if (pm_we !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL single_latency: we=%b rdy=%b required 1/0", pm_we, in_ready);
    end
    n_cmp++; if (pm_addr !== 8'h00 || pm_wdata !== 24'h212345) begin
      n_bad++; $display("FAIL single_write: addr=%h wdata=%h required 00/212345", pm_addr, pm_wdata);
    end
    send(8'h47, 0);
    n_cmp++; if ({done, cpu_hold, err} !== 4'b1000) begin
      n_bad++; $display("FAIL single_done: done/hold/err=%b required 1000", {done, cpu_hold, err});
    end
    n_cmp++; if (wa.size() !== 1 || ready_bad !== 0) begin
      n_bad++; $display("FAIL single_count: writes=%0d bad_ready=%0d required 1/0", wa.size(), ready_bad);
    end
  endtask

  task automatic test_three_words();
    clear_log();
    fw[0] = 24'h0ABCDE; fw[1] = 24'h180102; fw[2] = 24'h2CFF00;
    send(8'hA5, 1);
    n_cmp++; if ({done, cpu_hold} !== 2'b01) begin
      n_bad++; $display("FAIL restart_hold: done/hold=%b required 01", {done, cpu_hold});
    end
    send_body(3, 8'h00, 1);
    n_cmp++; if (wa.size() !== 3) begin
      n_bad++; $display("FAIL three_count: writes=%0d required 3", wa.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (wa[i] !== 8'(i) || wd[i] !== fw[i]) begin
          n_bad++; $display("FAIL three_write%0d: addr=%h data=%h required %h/%h", i, wa[i], wd[i], 8'(i), fw[i]);
        end
      end
    end
    n_cmp++; if ({done, cpu_hold, err, ready_bad != 0} !== 5'b10000) begin
      n_bad++; $display("FAIL three_done: done/hold/err/rdybad=%b required 10000", {done, cpu_hold, err, ready_bad != 0});
    end
  endtask

  task automatic test_bad_opcode();
    clear_log();
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h41, 0); send(8'h11, 0); send(8'h11, 0);
    send(8'hF8, 0); send(8'h00, 0); send(8'h00, 0);
    repeat (3) @(negedge clk);
    n_cmp++; if ({err, cpu_hold, done} !== 4'b0110) begin
      n_bad++; $display("FAIL badop_err: err/hold/done=%b required 0110", {err, cpu_hold, done});
    end
    n_cmp++; if (wa.size() !== 1 || wd[0] !== 24'h411111) begin
      n_bad++; $display("FAIL badop_writes: writes=%0d first=%h required 1/411111", wa.size(), wd[0]);
    end
    clear_log();
    send(8'h33, 0);
    n_cmp++; if (err !== 2'd1) begin
      n_bad++; $display("FAIL badop_junk: err=%0d required 1", err);
    end
    send(8'hA5, 0);
    n_cmp++; if (err !== 2'd0) begin
      n_bad++; $display("FAIL badop_clear: err=%0d required 0", err);
    end
    fw[0] = 24'h212345;
    send_body(1, 8'h00, 0);
    n_cmp++; if ({done, cpu_hold, err} !== 4'b1000 || wa.size() !== 1 || wa[0] !== 8'h00) begin
      n_bad++; $display("FAIL badop_reload: done/hold/err=%b writes=%0d required 1000/1", {done, cpu_hold, err}, wa.size());
    end
  endtask

  task automatic test_bad_chk();
    clear_log();
    fw[0] = 24'h301234; fw[1] = 24'h3ABEEF;
    send(8'hA5, 0);
    send_body(2, 8'h10, 0);
    n_cmp++; if ({err, done, cpu_hold} !== 4'b1001) begin
      n_bad++; $display("FAIL chk_err: err/done/hold=%b required 1001", {err, done, cpu_hold});
    end
    n_cmp++; if (wa.size() !== 2 || wd[1] !== 24'h3ABEEF) begin
      n_bad++; $display("FAIL chk_writes: writes=%0d second=%h required 2/3abeef", wa.size(), wd[1]);
    end
  endtask

  task automatic test_zero_count_and_junk();
    do_reset();
    clear_log();
    send(8'h00, 0);
    send(8'hFF, 0);
    n_cmp++; if ({in_ready, cpu_hold, done, err} !== 5'b11000 || wa.size() !== 0) begin
      n_bad++; $display("FAIL junk_idle: rdy/hold/done/err=%b writes=%0d required 11000/0", {in_ready, cpu_hold, done, err}, wa.size());
    end
    send(8'hA5, 0);
    send(8'h00, 0);
    n_cmp++; if (err !== 2'd3 || cpu_hold !== 1'b1) begin
      n_bad++; $display("FAIL zero_count: err=%0d hold=%b required 3/1", err, cpu_hold);
    end
  endtask

  task automatic test_reset_mid_word();
    clear_log();
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h21, 0);
    send(8'h23, 0);
    reset = 1'b1;
    #1;
    n_cmp++; if ({in_ready, pm_we, cpu_hold, done, err} !== 6'b101000 || pm_addr !== 8'h00) begin
      n_bad++; $display("FAIL midrst_vals: rdy/we/hold/done/err=%b addr=%h required 101000/00", {in_ready, pm_we, cpu_hold, done, err}, pm_addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (wa.size() !== 0) begin
      n_bad++; $display("FAIL midrst_nowrite: writes=%0d required 0", wa.size());
    end
    fw[0] = 24'h40AA55; fw[1] = 24'h100001;
    send(8'hA5, 0);
    send_body(2, 8'h00, 0);
    n_cmp++; if (wa.size() !== 2 || wa[0] !== 8'h00 || wd[0] !== 24'h40AA55 || done !== 1'b1) begin
      n_bad++; $display("FAIL midrst_reload: writes=%0d addr0=%h data0=%h done=%b required 2/00/40aa55/1", wa.size(), wa[0], wd[0], done);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_three_words();
    test_bad_opcode();
    test_bad_chk();
    test_zero_count_and_junk();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader for the picoMIPS core. It is the producer side of the instruction path: it packs incoming bytes into instruction words, checks each opcode, and writes the words into program memory.
- Holds the CPU in reset while loading, then releases it.
- Sits between a byte source (UART receiver or host bridge) and the program-memory write port.

Parameters:
- IWIDTH, 24, instruction word width in bits; must be a multiple of 8; opcode is bits [IWIDTH-1:IWIDTH-5].
- AWIDTH, 8, program-memory address width.
- HDR, 8'hA5, start-of-frame byte.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  byte available from source
- in_data  in  8  byte from source
- in_ready  out  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
- pm_we  out  1  program-memory write strobe, one cycle per word
- pm_addr  out  AWIDTH  write address
- pm_wdata  out  IWIDTH  instruction word
- cpu_hold  out  1  keep CPU in reset (1 = held)
- done  out  1  load completed successfully (level)
- err  out  2  error code: 0 none, 1 bad opcode, 2 checksum mismatch, 3 zero count

Behaviour:
- Reset values: in_ready=1, pm_we=0, pm_addr=0, pm_wdata=0, cpu_hold=1, done=0, err=0, state=IDLE.
- Reset is honoured mid-frame: the partial word is discarded and no write is issued.
- Frame format: HDR, COUNT (number of words, 1..255), COUNT words of IWIDTH/8 bytes each, most significant byte first, then CHK.
- CHK is the XOR of all word bytes. HDR and COUNT are excluded from CHK.
- States:
  - IDLE: accepts bytes; non-HDR bytes are dropped; HDR goes to COUNT. Entering IDLE sets cpu_hold=1, done=0, err=0, and clears the byte counter and address.
  - COUNT: next byte is latched as the word count. A value of 0 goes to ERROR with err=3; otherwise go to DATA.
  - DATA: bytes shift into the word register. On the last byte of a word, check the opcode against the implemented set from the shared opcode header (IMM, SWI, ADD, ADDI, MUL, MULI, ST_0, ST_1).
    - Invalid opcode: go to ERROR with err=1; no write is issued.
    - Valid opcode: next cycle pm_we=1 with pm_addr = word index and pm_wdata = assembled word. in_ready=0 in that cycle (one-cycle bubble).
    - After the write: pm_addr increments. After COUNT words, go to CHECK.
  - CHECK: next byte is compared with the running XOR. Match goes to DONE; mismatch goes to ERROR with err=2.
  - DONE: done=1, cpu_hold=0. An HDR byte restarts: go to COUNT, cpu_hold=1, done=0. Other bytes are dropped.
  - ERROR: cpu_hold=1, err holds its code. An HDR byte goes to COUNT with err cleared. Other bytes are dropped.
- Words already written before an error remain in memory. cpu_hold stays 1, so the CPU never runs a partial image.
- The running XOR and the byte-in-word counter clear on every HDR acceptance.
- pm_addr wraps modulo 2^AWIDTH. With AWIDTH=8 and COUNT up to 255 it never wraps within one frame.
- in_valid with in_ready=0 is a stall: the byte is not consumed, and the source must hold in_data.
- Latency: the pm_we pulse occurs exactly 1 cycle after the final byte of a word is accepted. done rises 1 cycle after CHK is accepted.

Test Plan:
- After reset, send A5,01,(ADDI word bytes),CHK=XOR → one pm_we pulse at pm_addr=0 with the exact word; done=1, cpu_hold=0, err=0; in_ready=0 only in the pm_we cycle.
- 3-word frame with in_valid toggling randomly → pm_addr 0,1,2 each written once in order; CHK correct → done.
- Second word with opcode 5'h1F (unimplemented) → no write for word 2; err=1; cpu_hold=1. Then a valid frame → err clears and the load succeeds.
- Correct words with a wrong CHK (one bit flipped) → err=2, done=0, cpu_hold=1; all words written.
- COUNT=0 → err=3. Separately: junk bytes 00,FF before HDR in IDLE → ignored, no state change.
- Assert reset mid-word (after 2 of 3 bytes) → no pm_we; outputs at reset values. The next full frame loads from pm_addr=0.
